fp_mul_pipe: RTL and testbench

Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier. It is the clocked successor to the combinational single-precision multiplier. It adds configurable exponent/mantissa widths, a valid/ready handshake with backpressure, and correct special-case results instead of X. Every output carries a sticky-free per-result flag vector. It sits in the FP datapath between the operand issue logic and the writeback arbiter.

---
 rtl/fp_pkg.sv | 43 ++++
 rtl/fp_round_rne.sv | 24 ++
 rtl/fp_mul_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types, flag layout and constant helpers for the parametrised FP datapath blocks.
package fp_pkg;

    typedef enum logic [2:0] {
        NORM = 3'd0,
        ZERO = 3'd1,
        INF  = 3'd2,
        NAN  = 3'd3,
        OVF  = 3'd4,
        UDF  = 3'd5
    } fp_class_e;

    localparam int FLAG_W       = 6;
    localparam int FLAG_NAN     = 5;
    localparam int FLAG_INF     = 4;
    localparam int FLAG_ZERO    = 3;
    localparam int FLAG_OVF     = 2;
    localparam int FLAG_UDF     = 1;
    localparam int FLAG_INEXACT = 0;

    localparam int SP_EXP_W = 8;
    localparam int SP_MAN_W = 23;

    // Field layout at default single-precision widths; modules build their own at EXP_W/MAN_W.
    typedef struct packed {
        logic                sign;
        logic [SP_EXP_W-1:0] exp;
        logic [SP_MAN_W-1:0] man;
    } fp_sp_t;

    function automatic int fp_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Canonical quiet NaN, right-aligned in 64 bits; callers truncate to their own width.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a stored mantissa given its guard, round and sticky bits.
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int MAN_W = 23
) (
    input  logic [MAN_W-1:0] man,
    input  logic             guard,
    input  logic             round,
    input  logic             sticky,
    output logic [MAN_W-1:0] man_rnd,
    output logic             carry,
    output logic             inexact
);

    logic inc;

    always_comb begin
        inc              = guard & (round | sticky | man[0]);
        {carry, man_rnd} = {1'b0, man} + {{MAN_W{1'b0}}, inc};
        inexact          = guard | round | sticky;
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier (unpack, normalise, round/pack)
// with a valid/ready handshake; a single advance enable stalls every stage together.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [FLAG_W-1:0]    flags,
    output fp_class_e            res_class
);

    localparam int BIAS = 2**(EXP_W-1) - 1;
    localparam int W    = fp_width(EXP_W, MAN_W);
    localparam int PW   = 2*MAN_W + 2;
    localparam int EW   = EXP_W + 2;

    localparam logic [W-1:0]         QNAN      = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic signed [EW-1:0] BIAS_S    = EW'(BIAS);
    localparam logic signed [EW-1:0] EXP_MAX   = EW'(2**EXP_W - 1);
    localparam logic signed [EW-1:0] EXP_FLOOR = '0;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_t;

    function automatic fp_class_e classify(input fp_t x);
        if (x.exp == '0) begin
            return ZERO;
        end else if (x.exp == '1) begin
            return (x.man == '0) ? INF : NAN;
        end else begin
            return NORM;
        end
    endfunction

    logic adv;

    fp_t                  a_f;
    fp_t                  b_f;
    fp_class_e            cls_a;
    fp_class_e            cls_b;
    logic                 nan_c;
    logic                 inf_c;
    logic                 zero_c;
    logic signed [EW-1:0] esum_c;
    logic [PW-1:0]        prod_c;

    logic                 s1_valid;
    logic                 s1_sign;
    logic                 s1_nan;
    logic                 s1_inf;
    logic                 s1_zero;
    logic signed [EW-1:0] s1_esum;
    logic [PW-1:0]        s1_prod;

    logic [PW-2:0]        norm_c;
    logic signed [EW-1:0] esum_n_c;

    logic                 s2_valid;
    logic                 s2_sign;
    logic                 s2_nan;
    logic                 s2_inf;
    logic                 s2_zero;
    logic signed [EW-1:0] s2_esum;
    logic [MAN_W-1:0]     s2_man;
    logic                 s2_guard;
    logic                 s2_round;
    logic                 s2_sticky;

    logic [MAN_W-1:0]     man_rnd;
    logic                 carry;
    logic                 rnd_inexact;
    logic signed [EW-1:0] esum_f;
    logic [W-1:0]         res_c;
    logic [FLAG_W-1:0]    flags_c;
    fp_class_e            cls_c;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign a_f      = a;
    assign b_f      = b;

    // Unpack: classify operands, combine exponents, full significand product.
    always_comb begin
        cls_a  = classify(a_f);
        cls_b  = classify(b_f);
        nan_c  = (cls_a == NAN) || (cls_b == NAN) ||
                 (cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF);
        inf_c  = (cls_a == INF) || (cls_b == INF);
        zero_c = (cls_a == ZERO) || (cls_b == ZERO);
        esum_c = $signed({2'b00, a_f.exp}) + $signed({2'b00, b_f.exp}) - BIAS_S;
        prod_c = PW'({1'b1, a_f.man}) * PW'({1'b1, b_f.man});
    end

    // Product of two [1,2) significands lies in [1,4): at most one bit of normalisation.
    always_comb begin
        norm_c   = s1_prod[PW-1] ? s1_prod[PW-2:0] : {s1_prod[PW-3:0], 1'b0};
        esum_n_c = s1_esum + $signed({{(EW-1){1'b0}}, s1_prod[PW-1]});
    end

    fp_round_rne #(
        .MAN_W (MAN_W)
    ) u_round (
        .man     (s2_man),
        .guard   (s2_guard),
        .round   (s2_round),
        .sticky  (s2_sticky),
        .man_rnd (man_rnd),
        .carry   (carry),
        .inexact (rnd_inexact)
    );

    // Round/pack with special-case priority; a rounding carry leaves man_rnd at zero.
    always_comb begin
        res_c   = '0;
        flags_c = '0;
        cls_c   = NORM;
        esum_f  = s2_esum + $signed({{(EW-1){1'b0}}, carry});
        if (s2_nan) begin
            res_c             = QNAN;
            flags_c[FLAG_NAN] = 1'b1;
            cls_c             = NAN;
        end else if (s2_inf) begin
            res_c             = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_c[FLAG_INF] = 1'b1;
            cls_c             = INF;
        end else if (s2_zero) begin
            res_c              = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
            flags_c[FLAG_ZERO] = 1'b1;
            cls_c              = ZERO;
        end else if (esum_f >= EXP_MAX) begin
            res_c                 = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_c[FLAG_OVF]     = 1'b1;
            flags_c[FLAG_INF]     = 1'b1;
            flags_c[FLAG_INEXACT] = 1'b1;
            cls_c                 = OVF;
        end else if (esum_f <= EXP_FLOOR) begin
            res_c                 = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
            flags_c[FLAG_UDF]     = 1'b1;
            flags_c[FLAG_ZERO]    = 1'b1;
            flags_c[FLAG_INEXACT] = 1'b1;
            cls_c                 = UDF;
        end else begin
            res_c                 = {s2_sign, esum_f[EXP_W-1:0], man_rnd};
            flags_c[FLAG_INEXACT] = rnd_inexact;
            cls_c                 = NORM;
        end
    end

    // All stages advance together; output registers only reload on a valid result.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_nan    <= 1'b0;
            s1_inf    <= 1'b0;
            s1_zero   <= 1'b0;
            s1_esum   <= '0;
            s1_prod   <= '0;
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_nan    <= 1'b0;
            s2_inf    <= 1'b0;
            s2_zero   <= 1'b0;
            s2_esum   <= '0;
            s2_man    <= '0;
            s2_guard  <= 1'b0;
            s2_round  <= 1'b0;
            s2_sticky <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            res_class <= ZERO;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_sign   <= a_f.sign ^ b_f.sign;
            s1_nan    <= nan_c;
            s1_inf    <= inf_c;
            s1_zero   <= zero_c;
            s1_esum   <= esum_c;
            s1_prod   <= prod_c;
            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_nan    <= s1_nan;
            s2_inf    <= s1_inf;
            s2_zero   <= s1_zero;
            s2_esum   <= esum_n_c;
            s2_man    <= norm_c[PW-2 -: MAN_W];
            s2_guard  <= norm_c[MAN_W];
            s2_round  <= norm_c[MAN_W-1];
            s2_sticky <= |norm_c[MAN_W-2:0];
            out_valid <= s2_valid;
            if (s2_valid) begin
                result    <= res_c;
                flags     <= flags_c;
                res_class <= cls_c;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe: single ops, specials, range limits, backpressure stream,
// mid-flight reset and a half-precision instance.
module tb_fp_mul_pipe;
    import fp_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [5:0]  flg;
        fp_class_e   cls;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic [5:0]  flg;
    fp_class_e   cls;

    logic        h_in_valid;
    logic        h_in_ready;
    logic [15:0] h_a;
    logic [15:0] h_b;
    logic        h_out_valid;
    logic [15:0] h_res;
    logic [5:0]  h_flg;
    fp_class_e   h_cls;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[10];

    always #5 clk = ~clk;

    fp_mul_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (op_a),
        .b         (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (res),
        .flags     (flg),
        .res_class (cls)
    );

    fp_mul_pipe #(
        .EXP_W (5),
        .MAN_W (10)
    ) dut_h (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (h_in_valid),
        .in_ready  (h_in_ready),
        .a         (h_a),
        .b         (h_b),
        .out_valid (h_out_valid),
        .out_ready (1'b1),
        .result    (h_res),
        .flags     (h_flg),
        .res_class (h_cls)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; presents one operand pair for exactly one rising edge.
    task automatic applyStimulus(input string tag, input logic [31:0] va, input logic [31:0] vb);
        in_valid = 1'b1;
        op_a     = va;
        op_b     = vb;
        #1;
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expectResult(input string tag, input vec_t v);
        int cyc = 1;
        while (!out_valid && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, "_latency"}, 64'(cyc), 64'(3));
        checkOutput({tag, "_result"}, 64'(res), 64'(v.res));
        checkOutput({tag, "_flags"}, 64'(flg), 64'(v.flg));
        checkOutput({tag, "_class"}, 64'(cls), 64'(v.cls));
    endtask

    initial begin
        int          sent;
        int          got;
        int          cyc;
        logic        stalled;
        logic [31:0] held_res;
        logic [5:0]  held_flg;
        vec_t        extra;

        vecs[0] = '{32'h40400000, 32'h40000000, 32'h40C00000, 6'b000000, NORM};
        vecs[1] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 6'b000000, NORM};
        vecs[2] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 6'b000001, NORM};
        vecs[3] = '{32'h3F800800, 32'h3F800800, 32'h3F801000, 6'b000001, NORM};
        vecs[4] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 6'b000001, NORM};
        vecs[5] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 6'b100000, NAN};
        vecs[6] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 6'b010000, INF};
        vecs[7] = '{32'h80000000, 32'h3F800000, 32'h80000000, 6'b001000, ZERO};
        vecs[8] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 6'b010101, OVF};
        vecs[9] = '{32'h00800000, 32'h3F000000, 32'h00000000, 6'b001011, UDF};

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        op_a       = '0;
        op_b       = '0;
        h_in_valid = 1'b0;
        h_a        = '0;
        h_b        = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_result", 64'(res), 64'(0));
        checkOutput("rst_flags", 64'(flg), 64'(0));
        checkOutput("rst_class", 64'(cls), 64'(ZERO));
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'(1));

        $display("[TB] directed single operations");
        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("v%0d", i), vecs[i].a, vecs[i].b);
            expectResult($sformatf("v%0d", i), vecs[i]);
        end
        extra = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 6'b100000, NAN};
        applyStimulus("nan_in", extra.a, extra.b);
        expectResult("nan_in", extra);
        extra = '{32'hC0400000, 32'h40000000, 32'hC0C00000, 6'b000000, NORM};
        applyStimulus("neg", extra.a, extra.b);
        expectResult("neg", extra);

        $display("[TB] backpressure stream");
        @(negedge clk);
        sent    = 0;
        got     = 0;
        stalled = 1'b0;
        held_res = '0;
        held_flg = '0;
        for (int c = 0; c < 300 && got < 10; c++) begin
            if (stalled) begin
                checkOutput("hold_valid", 64'(out_valid), 64'(1));
                checkOutput("hold_result", 64'(res), 64'(held_res));
                checkOutput("hold_flags", 64'(flg), 64'(held_flg));
            end
            out_ready = ($urandom_range(0, 2) != 0);
            in_valid  = (sent < 10) && ($urandom_range(0, 3) != 0);
            if (sent < 10) begin
                op_a = vecs[sent].a;
                op_b = vecs[sent].b;
            end
            #1;
            checkOutput("bp_in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                checkOutput($sformatf("bp%0d_result", got), 64'(res), 64'(vecs[got].res));
                checkOutput($sformatf("bp%0d_flags", got), 64'(flg), 64'(vecs[got].flg));
                got++;
            end
            if (in_valid && in_ready) sent++;
            stalled  = out_valid && !out_ready;
            held_res = res;
            held_flg = flg;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("bp_count", 64'(got), 64'(10));
        repeat (4) begin
            @(negedge clk);
            checkOutput("bp_no_extra", 64'(out_valid), 64'(0));
        end

        $display("[TB] reset with operations in flight");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            op_a     = vecs[i].a;
            op_b     = vecs[i].b;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("fill_out_valid", 64'(out_valid), 64'(1));
        checkOutput("fill_in_ready", 64'(in_ready), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("mid_rst_result", 64'(res), 64'(0));
        checkOutput("mid_rst_flags", 64'(flg), 64'(0));
        checkOutput("mid_rst_class", 64'(cls), 64'(ZERO));
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'(1));
        repeat (5) begin
            @(negedge clk);
            checkOutput("post_rst_no_stale", 64'(out_valid), 64'(0));
        end

        $display("[TB] half precision instance");
        h_in_valid = 1'b1;
        h_a        = 16'h4200;
        h_b        = 16'h4000;
        #1;
        checkOutput("h_in_ready", 64'(h_in_ready), 64'(1));
        @(negedge clk);
        h_in_valid = 1'b0;
        cyc = 1;
        while (!h_out_valid && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("h_latency", 64'(cyc), 64'(3));
        checkOutput("h_result", 64'(h_res), 64'(16'h4600));
        checkOutput("h_flags", 64'(h_flg), 64'(0));
        checkOutput("h_class", 64'(h_cls), 64'(NORM));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
